// File: rtl/pdp8l_iop_sequencer.sv
// rtl/pdp8l_iop_sequencer.sv - PDP-8/L IOT sequencer: start/settle/response/stop, response merge, IRQ mask.
// Optional trace register (ARM reg 3) is built only when IOPSEQ_TRACE_EN is defined.
module pdp8l_iop_sequencer #(
  parameter int NDEV    = 4,
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 iot_valid,
  input  logic [11:0]          mb,
  input  logic [11:0]          ac,
  output logic [11:0]          cpu_data,
  output logic                 cpu_acclr,
  output logic                 cpu_skip,
  output logic                 cpu_ack,
  output logic                 cpu_intrq,
  output logic                 iopstart,
  output logic                 iopstop,
  output logic [11:0]          ioopcode,
  output logic [11:0]          cputodev,
  input  logic [12*NDEV-1:0]   dev_data,
  input  logic [NDEV-1:0]      dev_acclr,
  input  logic [NDEV-1:0]      dev_skip,
  input  logic [NDEV-1:0]      dev_intrq,
  input  logic                 armwrite,
  input  logic [1:0]           armraddr,
  input  logic [1:0]           armwaddr,
  input  logic [31:0]          armwdata,
  output logic [31:0]          armrdata
);
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_SETTLE = 4'd1;
  localparam logic [3:0] ST_RESP   = 4'd2;
  localparam logic [3:0] ST_DRAIN  = 4'd3;
  localparam logic [7:0] SLOT_MASK = 8'((9'd1 << NDEV) - 9'd1);

  logic [3:0]  state_q, state_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [9:0]  tmo_cnt_q, tmo_cnt_d;
  logic        dropped_q, dropped_d;
  logic        iopstart_q, iopstart_d, iopstop_q, iopstop_d;
  logic        cpu_ack_q, cpu_ack_d, cpu_acclr_q, cpu_acclr_d, cpu_skip_q, cpu_skip_d;
  logic [11:0] cpu_data_q, cpu_data_d, ioopcode_q, ioopcode_d, cputodev_q, cputodev_d;
  logic [7:0]  intmask_q, intmask_d;
  logic        enable_q, enable_d, tmoflag_q, tmoflag_d;
  logic [11:0] data_or;
  logic        unused_armwdata;

  assign unused_armwdata = ^armwdata[30:8];

  always_comb begin
    data_or = 12'd0;
    for (int i = 0; i < NDEV; i++) data_or = data_or | dev_data[12*i +: 12];
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    dropped_d    = dropped_q;
    iopstart_d   = 1'b0;
    iopstop_d    = 1'b0;
    cpu_ack_d    = cpu_ack_q;
    cpu_acclr_d  = cpu_acclr_q;
    cpu_skip_d   = cpu_skip_q;
    cpu_data_d   = cpu_data_q;
    ioopcode_d   = ioopcode_q;
    cputodev_d   = cputodev_q;
    intmask_d    = intmask_q;
    enable_d     = enable_q;
    tmoflag_d    = tmoflag_q;
    if (armwrite && armwaddr == 2'd1) begin
      enable_d  = armwdata[31];
      intmask_d = armwdata[7:0] & SLOT_MASK;
    end
    if (armwrite && armwaddr == 2'd2 && armwdata[31]) tmoflag_d = 1'b0;
    // enable only gates acceptance; a sequence in flight always runs to its stop pulse
    case (state_q)
      ST_IDLE: begin
        if (enable_q && iot_valid && mb[11:9] == 3'o6) begin
          ioopcode_d   = mb;
          cputodev_d   = ac;
          iopstart_d   = 1'b1;
          settle_cnt_d = 4'd0;
          dropped_d    = 1'b0;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!iot_valid) dropped_d = 1'b1;
        if (settle_cnt_q == 4'(SETTLE)) begin
          if (dropped_q || !iot_valid) begin
            iopstop_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cpu_data_d  = data_or;
            cpu_acclr_d = |dev_acclr;
            cpu_skip_d  = |dev_skip;
            cpu_ack_d   = 1'b1;
            tmo_cnt_d   = 10'd0;
            state_d     = ST_RESP;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (!iot_valid || tmo_cnt_q == 10'(TIMEOUT)) begin
          cpu_data_d  = 12'd0;
          cpu_acclr_d = 1'b0;
          cpu_skip_d  = 1'b0;
          cpu_ack_d   = 1'b0;
          iopstop_d   = 1'b1;
          if (!iot_valid) begin
            state_d = ST_IDLE;
          end else begin
            tmoflag_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
      end
      ST_DRAIN: if (!iot_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;  settle_cnt_q <= 4'd0;  tmo_cnt_q <= 10'd0;  dropped_q <= 1'b0;
      iopstart_q <= 1'b0;  iopstop_q <= 1'b0;
      cpu_ack_q <= 1'b0;   cpu_acclr_q <= 1'b0;   cpu_skip_q <= 1'b0;  cpu_data_q <= 12'd0;
      ioopcode_q <= 12'd0; cputodev_q <= 12'd0;
      intmask_q <= 8'd0;   enable_q <= 1'b0;      tmoflag_q <= 1'b0;
    end else begin
      state_q <= state_d;  settle_cnt_q <= settle_cnt_d;  tmo_cnt_q <= tmo_cnt_d;  dropped_q <= dropped_d;
      iopstart_q <= iopstart_d;  iopstop_q <= iopstop_d;
      cpu_ack_q <= cpu_ack_d;    cpu_acclr_q <= cpu_acclr_d;  cpu_skip_q <= cpu_skip_d;  cpu_data_q <= cpu_data_d;
      ioopcode_q <= ioopcode_d;  cputodev_q <= cputodev_d;
      intmask_q <= intmask_d;    enable_q <= enable_d;        tmoflag_q <= tmoflag_d;
    end
  end

`ifdef IOPSEQ_TRACE_EN
  logic [15:0] iotcount_q, iotcount_d;
  logic [11:0] lastop_q, lastop_d;

  // ioopcode_q still holds the finishing IOT during its stop cycle
  always_comb begin
    iotcount_d = iotcount_q;
    lastop_d   = lastop_q;
    if (iopstop_q) begin
      iotcount_d = iotcount_q + 16'd1;
      lastop_d   = ioopcode_q;
    end
    if (armwrite && armwaddr == 2'd3) begin
      iotcount_d = 16'd0;
      lastop_d   = 12'd0;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      iotcount_q <= 16'd0;
      lastop_q   <= 12'd0;
    end else begin
      iotcount_q <= iotcount_d;
      lastop_q   <= lastop_d;
    end
  end
`endif

  always_comb begin
    armrdata = 32'd0;
    case (armraddr)
      2'd0:    armrdata = 32'h4953_1005;
      2'd1:    armrdata = {enable_q, 22'b0, 1'b0, intmask_q};
      2'd2:    armrdata = {tmoflag_q, 3'b0, state_q, 12'b0, ioopcode_q};
`ifdef IOPSEQ_TRACE_EN
      default: armrdata = {iotcount_q, 4'b0, lastop_q};
`else
      default: armrdata = 32'd0;
`endif
    endcase
  end

  assign cpu_intrq = enable_q & |(dev_intrq & intmask_q[NDEV-1:0]);
  assign cpu_data  = cpu_data_q;
  assign cpu_acclr = cpu_acclr_q;
  assign cpu_skip  = cpu_skip_q;
  assign cpu_ack   = cpu_ack_q;
  assign iopstart  = iopstart_q;
  assign iopstop   = iopstop_q;
  assign ioopcode  = ioopcode_q;
  assign cputodev  = cputodev_q;
endmodule

// File: tb/tb_pdp8l_iop_sequencer.sv
// tb/tb_pdp8l_iop_sequencer.sv - directed self-checking bench for pdp8l_iop_sequencer
module tb_pdp8l_iop_sequencer;
  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        iot_valid = 1'b0;
  logic [11:0] mb = 12'd0, ac = 12'd0;
  logic [11:0] cpu_data, ioopcode, cputodev;
  logic        cpu_acclr, cpu_skip, cpu_ack, cpu_intrq, iopstart, iopstop;
  logic [47:0] dev_data = 48'd0;
  logic [3:0]  dev_acclr = 4'd0, dev_skip = 4'd0, dev_intrq = 4'd0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0, armwaddr = 2'd0;
  logic [31:0] armwdata = 32'd0, armrdata, rd;

  int checks = 0, errors = 0;
  int start_cnt = 0, stop_cnt = 0, overlap_cnt = 0;
  int n, m, s0, p0;

  pdp8l_iop_sequencer #(.NDEV(4), .SETTLE(3), .TIMEOUT(1023)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .iot_valid(iot_valid), .mb(mb), .ac(ac),
    .cpu_data(cpu_data), .cpu_acclr(cpu_acclr), .cpu_skip(cpu_skip), .cpu_ack(cpu_ack),
    .cpu_intrq(cpu_intrq), .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
    .cputodev(cputodev), .dev_data(dev_data), .dev_acclr(dev_acclr), .dev_skip(dev_skip),
    .dev_intrq(dev_intrq), .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    #2;
    if (iopstart) start_cnt++;
    if (iopstop) stop_cnt++;
    if (iopstart && iopstop) overlap_cnt++;
  end

  task automatic tick;
    @(posedge CLOCK);
    #3;
  endtask

  task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a; armwdata = d; armwrite = 1'b1;
    tick;
    armwrite = 1'b0;
  endtask

  task automatic arm_read(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic start_iot(input logic [11:0] op, input logic [11:0] acv);
    mb = op; ac = acv; iot_valid = 1'b1;
    tick;
  endtask

  task automatic wait_ack(output int cnt);
    cnt = 0;
    while (!cpu_ack && cnt < 20) begin
      tick;
      cnt++;
    end
  endtask

  task automatic test_reset;
    repeat (2) tick;
    checks++; if ({iopstart, iopstop, cpu_ack, cpu_acclr, cpu_skip} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {iopstart, iopstop, cpu_ack, cpu_acclr, cpu_skip}); end
    checks++; if ({cpu_data, ioopcode, cputodev} !== 36'd0) begin errors++; $display("FAIL reset_data got %h exp 0", {cpu_data, ioopcode, cputodev}); end
    arm_read(2'd0, rd);
    checks++; if (rd !== 32'h4953_1005) begin errors++; $display("FAIL reg0_id got %h exp 49531005", rd); end
    arm_read(2'd1, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_reg1 got %h exp 0", rd); end
    arm_read(2'd2, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_reg2 got %h exp 0", rd); end
    RESET_N = 1'b1;
    tick;
  endtask

  task automatic test_skip_iot;
    arm_write(2'd1, 32'h8000_0000);
    dev_skip = 4'b0001;
    s0 = start_cnt; p0 = stop_cnt;
    start_iot(12'o6031, 12'o1234);
    checks++; if (iopstart !== 1'b1) begin errors++; $display("FAIL skip_start got %b exp 1", iopstart); end
    checks++; if ({ioopcode, cputodev} !== {12'o6031, 12'o1234}) begin errors++; $display("FAIL skip_latch got %o exp 60311234", {ioopcode, cputodev}); end
    repeat (3) tick;
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL skip_early_ack got %b exp 0", cpu_ack); end
    tick;
    checks++; if ({cpu_ack, cpu_skip} !== 2'b11) begin errors++; $display("FAIL skip_ack got %b exp 11", {cpu_ack, cpu_skip}); end
    iot_valid = 1'b0;
    tick;
    checks++; if ({iopstop, cpu_ack, cpu_skip} !== 3'b100) begin errors++; $display("FAIL skip_stop got %b exp 100", {iopstop, cpu_ack, cpu_skip}); end
    tick;
    checks++; if ((start_cnt - s0) != 1 || (stop_cnt - p0) != 1) begin errors++; $display("FAIL skip_pulses got %0d/%0d exp 1/1", start_cnt - s0, stop_cnt - p0); end
    dev_skip = 4'b0000;
  endtask

  task automatic test_data_merge;
    dev_data = {12'o0000, 12'o0000, 12'o0000, 12'o0301};
    dev_acclr = 4'b0001;
    start_iot(12'o6036, 12'o0000);
    wait_ack(n);
    checks++; if (n != 4) begin errors++; $display("FAIL merge_latency got %0d exp 4", n); end
    checks++; if ({cpu_data, cpu_acclr} !== {12'o0301, 1'b1}) begin errors++; $display("FAIL merge_cap got %o/%b exp 0301/1", cpu_data, cpu_acclr); end
    dev_data = {12'o0000, 12'o7000, 12'o0000, 12'o0000};
    dev_acclr = 4'b0000;
    repeat (5) tick;
    checks++; if ({cpu_data, cpu_acclr} !== {12'o0301, 1'b1}) begin errors++; $display("FAIL merge_hold got %o/%b exp 0301/1", cpu_data, cpu_acclr); end
    iot_valid = 1'b0;
    tick;
    checks++; if ({cpu_data, cpu_acclr, iopstop} !== {12'o0000, 1'b0, 1'b1}) begin errors++; $display("FAIL merge_clear got %o/%b/%b exp 0000/0/1", cpu_data, cpu_acclr, iopstop); end
    tick;
    dev_data = {12'o4040, 12'o0000, 12'o0000, 12'o0301};
    start_iot(12'o6036, 12'o0000);
    wait_ack(n);
    checks++; if (cpu_data !== 12'o4341) begin errors++; $display("FAIL merge_or got %o exp 4341", cpu_data); end
    iot_valid = 1'b0;
    repeat (2) tick;
    dev_data = 48'd0;
  endtask

  task automatic test_settle_drop;
    p0 = stop_cnt;
    start_iot(12'o6031, 12'o0000);
    iot_valid = 1'b0;
    repeat (3) tick;
    checks++; if (stop_cnt != p0) begin errors++; $display("FAIL drop_early_stop got %0d exp %0d", stop_cnt, p0); end
    tick;
    checks++; if ({iopstop, cpu_ack} !== 2'b10) begin errors++; $display("FAIL drop_stop got %b exp 10", {iopstop, cpu_ack}); end
    tick;
  endtask

  task automatic test_timeout;
    start_iot(12'o6031, 12'o0000);
    wait_ack(n);
    s0 = start_cnt;
    m = 0;
    while (!iopstop && m < 1100) begin
      tick;
      m++;
    end
    checks++; if (m != 1024) begin errors++; $display("FAIL tmo_cycles got %0d exp 1024", m); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL tmo_ack got %b exp 0", cpu_ack); end
    arm_read(2'd2, rd);
    checks++; if (rd !== 32'h8300_0C19) begin errors++; $display("FAIL tmo_reg2 got %h exp 83000c19", rd); end
    repeat (60) tick;
    checks++; if (start_cnt != s0) begin errors++; $display("FAIL tmo_restart got %0d exp %0d", start_cnt, s0); end
    iot_valid = 1'b0;
    repeat (2) tick;
    arm_read(2'd2, rd);
    checks++; if (rd !== 32'h8000_0C19) begin errors++; $display("FAIL tmo_idle_reg2 got %h exp 80000c19", rd); end
    arm_write(2'd2, 32'h8000_0000);
    arm_read(2'd2, rd);
    checks++; if (rd !== 32'h0000_0C19) begin errors++; $display("FAIL tmo_clear got %h exp 00000c19", rd); end
    start_iot(12'o6031, 12'o0000);
    checks++; if (iopstart !== 1'b1) begin errors++; $display("FAIL tmo_reaccept got %b exp 1", iopstart); end
    wait_ack(n);
    iot_valid = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_disabled;
    logic seen_ack;
    arm_write(2'd1, 32'h0000_0000);
    s0 = start_cnt; seen_ack = 1'b0;
    mb = 12'o6031; iot_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin tick; seen_ack |= cpu_ack; end
    checks++; if (start_cnt != s0 || seen_ack) begin errors++; $display("FAIL dis_enable0 got %0d/%b exp %0d/0", start_cnt, seen_ack, s0); end
    iot_valid = 1'b0;
    arm_write(2'd1, 32'h8000_0000);
    mb = 12'o7402; iot_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin tick; seen_ack |= cpu_ack; end
    checks++; if (start_cnt != s0 || seen_ack) begin errors++; $display("FAIL dis_nonio got %0d/%b exp %0d/0", start_cnt, seen_ack, s0); end
    iot_valid = 1'b0;
    tick;
  endtask

  task automatic test_intrq;
    arm_write(2'd1, 32'h8000_0002);
    dev_intrq = 4'b0011;
    #1;
    checks++; if (cpu_intrq !== 1'b1) begin errors++; $display("FAIL irq_hit got %b exp 1", cpu_intrq); end
    dev_intrq = 4'b0001;
    #1;
    checks++; if (cpu_intrq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", cpu_intrq); end
    arm_read(2'd1, rd);
    checks++; if (rd !== 32'h8000_0002) begin errors++; $display("FAIL irq_reg1 got %h exp 80000002", rd); end
    arm_write(2'd1, 32'h0000_00FF);
    arm_read(2'd1, rd);
    checks++; if (rd !== 32'h0000_000F) begin errors++; $display("FAIL irq_maskwidth got %h exp 0000000f", rd); end
    dev_intrq = 4'b1111;
    #1;
    checks++; if (cpu_intrq !== 1'b0) begin errors++; $display("FAIL irq_disabled got %b exp 0", cpu_intrq); end
    dev_intrq = 4'b0000;
    arm_write(2'd1, 32'h8000_0000);
  endtask

  task automatic test_reset_mid_resp;
    dev_skip = 4'b0001;
    dev_data = {36'd0, 12'o0301};
    start_iot(12'o6031, 12'o0777);
    wait_ack(n);
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL rst_pre_ack got %b exp 1", cpu_ack); end
    p0 = stop_cnt;
    RESET_N = 1'b0;
    #1;
    checks++; if ({cpu_ack, cpu_skip, cpu_acclr, iopstart, iopstop, cpu_data, ioopcode, cputodev} !== 41'd0) begin errors++; $display("FAIL rst_async got %h exp 0", {cpu_ack, cpu_skip, cpu_acclr, iopstart, iopstop, cpu_data, ioopcode, cputodev}); end
    iot_valid = 1'b0;
    repeat (3) tick;
    checks++; if (stop_cnt != p0) begin errors++; $display("FAIL rst_nostop got %0d exp %0d", stop_cnt, p0); end
    RESET_N = 1'b1;
    dev_skip = 4'b0000;
    dev_data = 48'd0;
    tick;
  endtask

  task automatic test_back_to_back_trace;
    arm_write(2'd1, 32'h8000_0000);
    start_iot(12'o6041, 12'o0000);
    wait_ack(n);
    iot_valid = 1'b0;
    tick;
    checks++; if (iopstop !== 1'b1) begin errors++; $display("FAIL b2b_stop got %b exp 1", iopstop); end
    mb = 12'o6046; iot_valid = 1'b1;
    tick;
    checks++; if ({iopstart, iopstop, ioopcode} !== {2'b10, 12'o6046}) begin errors++; $display("FAIL b2b_start got %b%b/%o exp 10/6046", iopstart, iopstop, ioopcode); end
    wait_ack(n);
    iot_valid = 1'b0;
    repeat (2) tick;
    start_iot(12'o6031, 12'o0000);
    wait_ack(n);
    iot_valid = 1'b0;
    repeat (2) tick;
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL start_stop_overlap got %0d exp 0", overlap_cnt); end
    arm_read(2'd3, rd);
`ifdef IOPSEQ_TRACE_EN
    checks++; if (rd !== 32'h0003_0C19) begin errors++; $display("FAIL trace_reg3 got %h exp 00030c19", rd); end
`else
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL trace_reg3 got %h exp 0", rd); end
`endif
    arm_write(2'd3, 32'hFFFF_FFFF);
    arm_read(2'd3, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL trace_clear got %h exp 0", rd); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_skip_iot;
    test_data_merge;
    test_settle_drop;
    test_timeout;
    test_disabled;
    test_intrq;
    test_reset_mid_resp;
    test_back_to_back_trace;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
